// File: rtl/io_map_pkg.sv
// -----------------------------------------------------------------------------
// io_map_pkg
// Shared address map for the memory-mapped output peripheral.
//   - Word addresses of every I/O register and the I/O window page.
//   - reg_idx_e: register index used by the decoder and the read mux.
//   - decode_reg(): maps a word address (byte address [31:2]) to a reg index.
//   - in_io_window(): true when a byte address lies in 0x7000-0x7FFF.
// -----------------------------------------------------------------------------
package io_map_pkg;

    localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
    localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
    localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
    localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;
    localparam logic [31:0] ADDR_LCD    = 32'h0000_7030;
    localparam logic [31:0] ADDR_SW     = 32'h0000_7800;

    // Upper 20 address bits shared by everything in 0x7000-0x7FFF.
    localparam logic [19:0] IO_WINDOW_PAGE = 20'h0_0007;

    // Registers that are always built (LEDR, LEDG, HEX_LO, HEX_HI).
    localparam int NUM_BASE_REGS = 4;

    typedef enum logic [2:0] {
        REG_LEDR   = 3'd0,
        REG_LEDG   = 3'd1,
        REG_HEX_LO = 3'd2,
        REG_HEX_HI = 3'd3,
        REG_LCD    = 3'd4,
        REG_SW     = 3'd5,
        REG_NONE   = 3'd6
    } reg_idx_e;

    function automatic reg_idx_e decode_reg(input logic [29:0] word_addr);
        reg_idx_e idx;
        idx = REG_NONE;
        if (word_addr == ADDR_LEDR[31:2]) begin
            idx = REG_LEDR;
        end else if (word_addr == ADDR_LEDG[31:2]) begin
            idx = REG_LEDG;
        end else if (word_addr == ADDR_HEX_LO[31:2]) begin
            idx = REG_HEX_LO;
        end else if (word_addr == ADDR_HEX_HI[31:2]) begin
            idx = REG_HEX_HI;
        end else if (word_addr == ADDR_LCD[31:2]) begin
            idx = REG_LCD;
        end else if (word_addr == ADDR_SW[31:2]) begin
            idx = REG_SW;
        end
        return idx;
    endfunction

    function automatic logic in_io_window(input logic [31:0] addr);
        return (addr[31:12] == IO_WINDOW_PAGE);
    endfunction

endpackage

// File: rtl/io_strb_reg.sv
// -----------------------------------------------------------------------------
// io_strb_reg
// 32-bit register with per-byte-lane write enables and asynchronous reset.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears the register
//   wr_en   : register selected for a write this cycle
//   strb    : byte-lane enables, lane 0 = bits [7:0]
//   wr_data : write data, lanes aligned to the register
//   q       : register contents
// -----------------------------------------------------------------------------
module io_strb_reg
    import io_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  strb,
    input  logic [31:0] wr_data,
    output logic [31:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                end else if (wr_en && strb[gi]) begin
                    lane_reg <= wr_data[gi*8 +: 8];
                end
            end

            assign q[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/output_periph.sv
// -----------------------------------------------------------------------------
// output_periph
// Memory-mapped output peripheral: LEDR, LEDG, two HEX words, optional LCD
// register and a read-only, synchronised switch register.
//
// Optional feature: define OUTPUT_PERIPH_LCD_EN to build the LCD register at
// 0x7030. Without it o_io_lcd is 0, 0x7030 reads 0 and stores to it are
// treated as unmapped (o_addr_err set).
//
// Ports
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_lsu_addr/i_st_data    : byte address and lane-aligned store data
//   i_st_strb/i_lsu_wren    : byte enables and store request
//   i_io_sw                 : raw asynchronous switches
//   o_ld_data               : combinational read data for i_lsu_addr
//   o_io_ledr/ledg/lcd      : register contents
//   o_io_hex0..7            : seven-segment digits (bits [6:0] of each byte)
//   o_ledr_wr               : one-cycle pulse after an LEDR store
//   o_addr_err              : last store hit an unmapped I/O window address
// -----------------------------------------------------------------------------
module output_periph
    import io_map_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_st_strb,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    output logic        o_ledr_wr,
    output logic        o_addr_err
);

    reg_idx_e   reg_sel;
    logic       in_window;
    logic       lcd_writable;
    logic       writable;
    logic       store_req;
    logic       wr_hit;

    logic [NUM_BASE_REGS-1:0] base_wr_en;
    logic [31:0]              wreg_q [NUM_BASE_REGS];
    logic [31:0]              lcd_q;

    logic [31:0] sw_meta_reg;
    logic [31:0] sw_sync_reg;
    logic        ledr_wr_reg;
    logic        ledr_wr_next;
    logic        addr_err_reg;
    logic        addr_err_next;

    // Byte offset within a word does not take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_lsu_addr[1:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign reg_sel   = decode_reg(i_lsu_addr[31:2]);
    assign in_window = in_io_window(i_lsu_addr);

    // A store with no strobe bits is not a store at all.
    assign store_req = i_lsu_wren && (i_st_strb != 4'b0000);

`ifdef OUTPUT_PERIPH_LCD_EN
    assign lcd_writable = (reg_sel == REG_LCD);
`else
    assign lcd_writable = 1'b0;
`endif

    assign writable = (reg_sel == REG_LEDR)   || (reg_sel == REG_LEDG) ||
                      (reg_sel == REG_HEX_LO) || (reg_sel == REG_HEX_HI) ||
                      lcd_writable;

    assign wr_hit = store_req && writable;

    // ------------------------------------------------------------------
    // Writable registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BASE_REGS; gi++) begin : g_base_reg
            assign base_wr_en[gi] = wr_hit && (reg_sel == reg_idx_e'(gi));

            io_strb_reg u_reg (
                .clk     (i_clk),
                .rst     (i_reset),
                .wr_en   (base_wr_en[gi]),
                .strb    (i_st_strb),
                .wr_data (i_st_data),
                .q       (wreg_q[gi])
            );
        end
    endgenerate

`ifdef OUTPUT_PERIPH_LCD_EN
    io_strb_reg u_lcd_reg (
        .clk     (i_clk),
        .rst     (i_reset),
        .wr_en   (wr_hit && lcd_writable),
        .strb    (i_st_strb),
        .wr_data (i_st_data),
        .q       (lcd_q)
    );
`else
    assign lcd_q = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // Switch synchroniser: two flops, reads see the second one.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sw_meta_reg <= 32'h0000_0000;
            sw_sync_reg <= 32'h0000_0000;
        end else begin
            sw_meta_reg <= i_io_sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    always_comb begin
        ledr_wr_next  = wr_hit && (reg_sel == REG_LEDR);
        addr_err_next = addr_err_reg;
        if (store_req) begin
            if (writable) begin
                addr_err_next = 1'b0;
            end else if (in_window) begin
                // Includes SW, which is read-only, and LCD when not built.
                addr_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr_wr_reg  <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            ledr_wr_reg  <= ledr_wr_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, zero wait)
    // ------------------------------------------------------------------
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (reg_sel)
            REG_LEDR:   o_ld_data = wreg_q[0];
            REG_LEDG:   o_ld_data = wreg_q[1];
            REG_HEX_LO: o_ld_data = wreg_q[2];
            REG_HEX_HI: o_ld_data = wreg_q[3];
            REG_LCD:    o_ld_data = lcd_q;
            REG_SW:     o_ld_data = sw_sync_reg;
            default:    o_ld_data = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_io_ledr = wreg_q[0];
    assign o_io_ledg = wreg_q[1];
    assign o_io_lcd  = lcd_q;

    // Bit 7 of each HEX byte is storage only.
    assign o_io_hex0 = wreg_q[2][6:0];
    assign o_io_hex1 = wreg_q[2][14:8];
    assign o_io_hex2 = wreg_q[2][22:16];
    assign o_io_hex3 = wreg_q[2][30:24];
    assign o_io_hex4 = wreg_q[3][6:0];
    assign o_io_hex5 = wreg_q[3][14:8];
    assign o_io_hex6 = wreg_q[3][22:16];
    assign o_io_hex7 = wreg_q[3][30:24];

    assign o_ledr_wr  = ledr_wr_reg;
    assign o_addr_err = addr_err_reg;

endmodule
